// File: rtl/seg7_capture_decoder_if.sv
// rtl/seg7_capture_decoder_if.sv - display bus and capture results for seg7_capture_decoder (SEG7_ERR_COUNT_EN adds err_cnt)
interface seg7_capture_decoder_if #(
  parameter int NUM_DIGITS = 2
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    upd;
  logic [2:0]              upd_idx;
  logic                    bad;
`ifdef SEG7_ERR_COUNT_EN
  logic [7:0]              err_cnt;
`endif

  // Display driver side: drives the multiplexed bus, observes the recovered digits.
  modport master (
    output seg_in,
    output dig_en,
    input  digits,
    input  digit_valid,
    input  upd,
    input  upd_idx,
    input  bad
`ifdef SEG7_ERR_COUNT_EN
    , input err_cnt
`endif
  );

  // Decoder side: watches the bus, reports the recovered digits.
  modport slave (
    input  seg_in,
    input  dig_en,
    output digits,
    output digit_valid,
    output upd,
    output upd_idx,
    output bad
`ifdef SEG7_ERR_COUNT_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/seg7_capture_decoder.sv
// rtl/seg7_capture_decoder.sv - debounced 7-segment bus capture to hex nibbles (SEG7_ERR_COUNT_EN adds err_cnt)
module seg7_capture_decoder #(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4
) (
  input logic                   clk,
  input logic                   reset,
  seg7_capture_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = NUM_DIGITS + 7;
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t                  state;
  logic [CW-1:0]           count;
  logic [SW-1:0]           s_q;
  logic [SW-1:0]           s_prev;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   valid_q;
  logic                    upd_q;
  logic                    bad_q;
  logic [2:0]              idx_q;

  logic [NUM_DIGITS-1:0]   s_dig;
  logic [6:0]              s_seg;
  logic                    legal;
  logic                    same;
  logic [2:0]              idx;
  logic [CW-1:0]           ncount;
  logic                    capture;
  logic [4:0]              dec;

  // Segment pattern to {legal, nibble}; anything outside the hex font is illegal.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h7E:   decode = {1'b1, 4'h0};
      7'h30:   decode = {1'b1, 4'h1};
      7'h6D:   decode = {1'b1, 4'h2};
      7'h79:   decode = {1'b1, 4'h3};
      7'h33:   decode = {1'b1, 4'h4};
      7'h5B:   decode = {1'b1, 4'h5};
      7'h5F:   decode = {1'b1, 4'h6};
      7'h70:   decode = {1'b1, 4'h7};
      7'h7F:   decode = {1'b1, 4'h8};
      7'h7B:   decode = {1'b1, 4'h9};
      7'h77:   decode = {1'b1, 4'hA};
      7'h1F:   decode = {1'b1, 4'hB};
      7'h4E:   decode = {1'b1, 4'hC};
      7'h3D:   decode = {1'b1, 4'hD};
      7'h4F:   decode = {1'b1, 4'hE};
      7'h47:   decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  // Register the raw bus once and keep the previous sample for stability comparison.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q    <= '0;
      s_prev <= '0;
    end else begin
      s_q    <= {bus.dig_en, bus.seg_in};
      s_prev <= s_q;
    end
  end

  // Strobe legality, digit index, and the stability count this edge would produce.
  always_comb begin
    s_dig = s_q[SW-1:7];
    s_seg = s_q[6:0];
    legal = $onehot(s_dig);
    same  = (s_q == s_prev);
    idx   = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s_dig[i]) idx = 3'(i);
    end
    if (!legal)
      ncount = '0;
    else if (!same || state == IDLE)
      ncount = ONE_C;
    else if (state == HOLD || count >= STABLE_C)
      ncount = count;
    else
      ncount = count + ONE_C;
    // A held pattern is never re-captured; any other path captures when the run reaches the threshold.
    capture = legal && !(state == HOLD && same) && (ncount == STABLE_C);
    dec     = decode(s_seg);
  end

  // Settle/hold FSM with registered capture results; only the strobed digit is ever written.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      upd_q    <= 1'b0;
      bad_q    <= 1'b0;
      idx_q    <= 3'd0;
    end else begin
      upd_q <= 1'b0;
      bad_q <= 1'b0;
      count <= ncount;
      case (state)
        IDLE:    state <= legal ? (capture ? HOLD : SETTLE) : IDLE;
        SETTLE:  state <= !legal ? IDLE : (capture ? HOLD : SETTLE);
        HOLD:    state <= same ? HOLD : (!legal ? IDLE : (capture ? HOLD : SETTLE));
        default: state <= IDLE;
      endcase
      if (capture) begin
        idx_q <= idx;
        if (dec[4]) upd_q <= 1'b1;
        else        bad_q <= 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (3'(i) == idx) begin
            valid_q[i] <= dec[4];
            if (dec[4]) digits_q[4*i +: 4] <= dec[3:0];
          end
        end
      end
    end
  end

`ifdef SEG7_ERR_COUNT_EN
  logic [7:0] err_q;

  // Saturating count of rejected stable patterns, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 8'h00;
    else if (capture && !dec[4] && err_q != 8'hFF)
      err_q <= err_q + 8'h01;
  end

  assign bus.err_cnt = err_q;
`endif

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.upd         = upd_q;
  assign bus.bad         = bad_q;
  assign bus.upd_idx     = idx_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// tb/tb_seg7_capture_decoder.sv - directed bench with run-length reference model for seg7_capture_decoder
module tb_seg7_capture_decoder;

  localparam int ND = 2;
  localparam int SC = 4;
  localparam int SW = ND + 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg7_capture_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg7_capture_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [6:0] FONT [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                       7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int n_run = 0;
  int n_fail = 0;
  int upd_seen = 0;
  int bad_seen = 0;

  // Reference model: a capture happens when the run of identical legal samples reaches SC.
  logic [SW-1:0] m_last;
  int            m_run;
  logic [3:0]    m_dig [ND];
  logic [ND-1:0] m_valid;
  logic          m_upd;
  logic          m_bad;
  logic [2:0]    m_idx;
  int            m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [SW-1:0] x;
    logic [ND-1:0] d;
    int            k;
    bit            found;
    x = {bus.dig_en, bus.seg_in};
    if (reset) begin
      m_last = '0;
      m_run = 0;
      for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
      m_valid = '0;
      m_upd = 1'b0;
      m_bad = 1'b0;
      m_idx = 3'd0;
      m_err = 0;
    end else begin
      m_upd = 1'b0;
      m_bad = 1'b0;
      d = m_last[SW-1:7];
      if ($countones(d) == 1 && m_run == SC) begin
        k = 0;
        for (int i = 0; i < ND; i++) if (d[i]) k = i;
        found = 1'b0;
        for (int n = 0; n < 16; n++) begin
          if (FONT[n] == m_last[6:0]) begin
            found = 1'b1;
            m_dig[k] = 4'(n);
          end
        end
        m_idx = 3'(k);
        m_valid[k] = found;
        if (found) m_upd = 1'b1;
        else begin
          m_bad = 1'b1;
          if (m_err < 255) m_err++;
        end
      end
      m_run = (x == m_last) ? m_run + 1 : 1;
      m_last = x;
    end
  endtask

  // One clock: advance the model at the edge, compare everything at the falling edge.
  task automatic step();
    logic [4*ND-1:0] exp_digits;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < ND; i++) exp_digits[4*i +: 4] = m_dig[i];
    check("digits", 32'(bus.digits), 32'(exp_digits));
    check("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
    check("upd", 32'(bus.upd), 32'(m_upd));
    check("bad", 32'(bus.bad), 32'(m_bad));
    check("upd_idx", 32'(bus.upd_idx), 32'(m_idx));
`ifdef SEG7_ERR_COUNT_EN
    check("err_cnt", 32'(bus.err_cnt), 32'(m_err));
`endif
    if (bus.upd === 1'b1) upd_seen++;
    if (bus.bad === 1'b1) bad_seen++;
  endtask

  task automatic hold(input logic [6:0] s, input logic [ND-1:0] d, input int n);
    bus.seg_in = s;
    bus.dig_en = d;
    repeat (n) step();
  endtask

  initial begin
    int u0, b0, n;
    bus.seg_in = 7'h00;
    bus.dig_en = '0;
    reset = 1'b1;
    repeat (3) step();
    check("reset_digits", 32'(bus.digits), 32'h0);
    check("reset_valid", 32'(bus.digit_valid), 32'h0);
    check("reset_upd_idx", 32'(bus.upd_idx), 32'h0);
    reset = 1'b0;

    // 1: single stable zero on digit 0
    u0 = upd_seen;
    hold(7'h7E, 2'b01, 10);
    check("t1_upd_count", 32'(upd_seen - u0), 32'd1);
    check("t1_digit0", 32'(bus.digits[3:0]), 32'h0);
    check("t1_valid", 32'(bus.digit_valid), 32'h1);
    check("t1_upd_idx", 32'(bus.upd_idx), 32'h0);

    // 2: full font sweep on digit 1
    u0 = upd_seen;
    for (int c = 0; c < 16; c++) hold(FONT[c], 2'b10, 6);
    check("t2_upd_count", 32'(upd_seen - u0), 32'd16);
    check("t2_digit1", 32'(bus.digits[7:4]), 32'hF);
    check("t2_digit0", 32'(bus.digits[3:0]), 32'h0);
    check("t2_valid", 32'(bus.digit_valid), 32'h3);
    check("t2_upd_idx", 32'(bus.upd_idx), 32'h1);

    // 3: blank after a valid 8 is rejected and keeps the old nibble
    hold(7'h7F, 2'b01, 6);
    check("t3_digit0_8", 32'(bus.digits[3:0]), 32'h8);
    b0 = bad_seen;
    u0 = upd_seen;
    hold(7'h00, 2'b01, 6);
    check("t3_bad_count", 32'(bad_seen - b0), 32'd1);
    check("t3_upd_count", 32'(upd_seen - u0), 32'd0);
    check("t3_valid0", 32'(bus.digit_valid[0]), 32'h0);
    check("t3_digit0", 32'(bus.digits[3:0]), 32'h8);
`ifdef SEG7_ERR_COUNT_EN
    check("t3_err_cnt", 32'(bus.err_cnt), 32'd1);
`endif

    // 4: glitching pattern never settles, then a steady 6 is taken once
    u0 = upd_seen;
    b0 = bad_seen;
    for (int t = 0; t < 10; t++) hold((t % 2 == 0) ? 7'h5B : 7'h5F, 2'b01, 2);
    check("t4_glitch_upd", 32'(upd_seen - u0), 32'd0);
    check("t4_glitch_bad", 32'(bad_seen - b0), 32'd0);
    hold(7'h5F, 2'b01, 5);
    check("t4_upd_count", 32'(upd_seen - u0), 32'd1);
    check("t4_digit0", 32'(bus.digits[3:0]), 32'h6);

    // 5: multi-hot and zero-hot strobes are ignored
    u0 = upd_seen;
    b0 = bad_seen;
    hold(7'h30, 2'b11, 10);
    hold(7'h30, 2'b00, 10);
    check("t5_upd", 32'(upd_seen - u0), 32'd0);
    check("t5_bad", 32'(bad_seen - b0), 32'd0);
    check("t5_digits", 32'(bus.digits), 32'hF6);

    // 6: reset mid-settle discards progress; a full settle is needed after release
    hold(7'h33, 2'b01, 4);
    reset = 1'b1;
    step();
    step();
    check("t6_reset_digits", 32'(bus.digits), 32'h0);
    check("t6_reset_valid", 32'(bus.digit_valid), 32'h0);
    check("t6_reset_upd", 32'(bus.upd), 32'h0);
    reset = 1'b0;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (bus.upd === 1'b1) break;
    end
    check("t6_latency", 32'(n), 32'd5);
    check("t6_digit0", 32'(bus.digits[3:0]), 32'h4);
    hold(7'h33, 2'b01, 4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
